// File: rtl/adc_capture_pkg.sv
// Shared constants and the FSM state encoding for the ADC capture block.
package adc_capture_pkg;

  localparam int DEPTH_LOG2_DEF = 10;
  localparam int DATA_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port and one registered read port
// with 1-cycle latency. The read register holds its value when not enabled.
module capture_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              adc_clk,
  input  logic              rstn,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array deliberately has no reset so it maps onto block RAM;
  // only the output register is cleared.
  always_ff @(posedge adc_clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge adc_clk) begin
    if (!rstn)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Triggered ADC capture: pre/post-trigger sample window into a circular buffer,
// then sequential readout starting from the oldest held sample.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  adc_clk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  arm,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_rising,
  input  logic                  force_trig,
  input  logic [DEPTH_LOG2-1:0] pre_trig,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [2:0]            state,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  cap_state_e            state_q, state_d;
  logic [DATA_W-1:0]     s0_q, s1_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
  logic [DEPTH_LOG2-1:0] pre_q, pre_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      post_len;
  logic                  rd_valid_q;
  logic                  writing, trig_hit, rd_fire;

  // Samples still owed after the trigger so the buffer ends up exactly full.
  assign post_len = CNT_W'(DEPTH) - CNT_W'(pre_q);

  assign trig_hit = force_trig ||
                    (trig_rising ? (s1_q <  trig_level && s0_q >= trig_level)
                                 : (s1_q >= trig_level && s0_q <  trig_level));

  assign writing = (state_q inside {ST_PRE, ST_WAIT, ST_POST}) && !arm;
  assign rd_fire = rd_en && (state_q == ST_DONE) && !arm;

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;

    if (writing) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    if (arm) begin
      state_d  = ST_PRE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      pre_d    = pre_trig;
    end else begin
      case (state_q)
        ST_PRE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pre_q == '0 || cnt_d == CNT_W'(pre_q)) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = CNT_W'(1);
            state_d     = (post_len == CNT_W'(1)) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == post_len) state_d = ST_DONE;
        end
        default: ;
      endcase
    end

    // Readout starts at the oldest sample of the window.
    if (state_q != ST_DONE && state_d == ST_DONE) rd_ptr_d = trig_addr_d - pre_q;
  end

  // NOTE: reset is synchronous, so only the clock is in the event list, and
  // all state uses non-blocking assignments to avoid ordering races.
  always_ff @(posedge adc_clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      s0_q        <= '0;
      s1_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0_q        <= adc_data;
      s1_q        <= s0_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_fire;
    end
  end

  capture_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_ram (
    .adc_clk (adc_clk),
    .rstn    (rstn),
    .we_i    (writing),
    .waddr_i (wr_ptr_q),
    .wdata_i (s0_q),
    .re_i    (rd_fire),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign state     = state_q;
  assign done      = (state_q == ST_DONE);
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: a sample-stream model predicts the
// trigger point, the captured window, trig_addr and the completion time.
module tb_adc_capture;

  localparam int DEPTH_LOG2 = 10;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  adc_clk = 1'b0;
  logic                  rstn, arm, trig_rising, force_trig, rd_en;
  logic [DATA_W-1:0]     adc_data, trig_level;
  logic [DEPTH_LOG2-1:0] pre_trig;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid, done;
  logic [2:0]            state;
  logic [DEPTH_LOG2-1:0] trig_addr;

  adc_capture #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) dut (
    .adc_clk     (adc_clk),
    .rstn        (rstn),
    .adc_data    (adc_data),
    .arm         (arm),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .force_trig  (force_trig),
    .pre_trig    (pre_trig),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .state       (state),
    .done        (done),
    .trig_addr   (trig_addr)
  );

  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Inputs presented at each rising edge, indexed by edge number.
  logic [7:0] xs[$];
  bit         fs[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int         data_mode;  // 0 ramp, 1 constant, 2 random
  logic [7:0] ramp_v, const_v;
  int         arm_edge, done_edge, trig_k, fd;
  logic [7:0] v;

  task automatic step();
    case (data_mode)
      0:       begin adc_data = ramp_v; ramp_v++; end
      1:       adc_data = const_v;
      default: adc_data = 8'($urandom);
    endcase
    xs.push_back(adc_data);
    fs.push_back(force_trig);
    @(posedge adc_clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    done_edge = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        done_edge = xs.size() - 1;
        return;
      end
    end
  endtask

  task automatic wait_wait_state();
    for (int i = 0; i < 2000 && state !== 3'd2; i++) step();
  endtask

  task automatic run_capture(input int p, input logic [7:0] lvl, input bit rising,
                             input bit use_force);
    trig_level  = lvl;
    trig_rising = rising;
    pre_trig    = DEPTH_LOG2'(p);
    arm         = 1'b1;
    arm_edge    = xs.size();
    step();
    arm      = 1'b0;
    pre_trig = DEPTH_LOG2'($urandom);  // must be ignored after arm
    if (use_force) begin
      wait_wait_state();
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
    end
    wait_done(6000);
  endtask

  // Trigger sample index: first sample after the pre-trigger fill whose
  // (previous, current) pair crosses the level, or whose WAIT cycle saw force.
  function automatic int find_trig(int a, int p, logic [7:0] lvl, bit rising);
    for (int k = a + ((p == 0) ? 1 : p); k + 1 < xs.size(); k++) begin
      if (fs[k+1]) return k;
      if (rising  && xs[k-1] <  lvl && xs[k] >= lvl) return k;
      if (!rising && xs[k-1] >= lvl && xs[k] <  lvl) return k;
    end
    return -1;
  endfunction

  task automatic build_expected(input int a, input int p, input logic [7:0] lvl, input bit rising);
    int idx;
    trig_k = find_trig(a, p, lvl, rising);
    exp_q.delete();
    if (trig_k < 0) return;
    for (int i = 0; i < DEPTH; i++) begin
      idx = trig_k - p + i;
      exp_q.push_back((idx < xs.size()) ? xs[idx] : 8'hxx);
    end
  endtask

  task automatic do_reads(input int n);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      step();
      if (rd_valid === 1'b1) got_q.push_back(rd_data);
    end
    rd_en = 1'b0;
    step();
  endtask

  function automatic int first_diff();
    if (exp_q.size() != DEPTH) return 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i % DEPTH]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    n_checks++; if (state !== 3'd0)  begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if (trig_addr !== '0) begin n_fail++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    rstn = 1'b1;
    repeat (3) step();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_without_arm: got %0d want 0", state); end
  endtask

  task automatic test_rising();
    data_mode = 0;
    ramp_v    = 8'h00;
    run_capture(16, 8'h80, 1'b1, 1'b0);
    build_expected(arm_edge, 16, 8'h80, 1'b1);
    n_checks++; if (trig_k < 0 || done_edge !== trig_k + DEPTH - 16) begin
      n_fail++; $display("FAIL rise_done_time: edge %0d want %0d", done_edge, trig_k + DEPTH - 16); end
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL rise_state_done: got %0d want 4", state); end
    n_checks++; if (trig_addr !== DEPTH_LOG2'(trig_k - arm_edge)) begin
      n_fail++; $display("FAIL rise_trig_addr: got %0d want %0d", trig_addr, trig_k - arm_edge); end
    do_reads(DEPTH);
    n_checks++; if (got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL rise_read_count: got %0d want %0d", got_q.size(), DEPTH); end
    fd = first_diff();
    n_checks++; if (fd >= 0) begin
      n_fail++; $display("FAIL rise_window: read %0d got %h want %h", fd, got_at(fd), exp_q[fd % DEPTH]); end
    n_checks++; if (got_at(0) !== 8'h70) begin n_fail++; $display("FAIL rise_first: got %h want 70", got_at(0)); end
    n_checks++; if (got_at(16) !== 8'h80) begin n_fail++; $display("FAIL rise_17th: got %h want 80", got_at(16)); end
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== got_at(DEPTH - 1)) begin
      n_fail++; $display("FAIL rise_hold: valid %b data %h want 0 %h", rd_valid, rd_data, got_at(DEPTH - 1)); end
  endtask

  task automatic test_falling();
    data_mode = 0;
    run_capture(4, 8'h80, 1'b0, 1'b0);
    build_expected(arm_edge, 4, 8'h80, 1'b0);
    n_checks++; if (trig_k < 0 || done_edge !== trig_k + DEPTH - 4) begin
      n_fail++; $display("FAIL fall_done_time: edge %0d want %0d", done_edge, trig_k + DEPTH - 4); end
    n_checks++; if (trig_addr !== DEPTH_LOG2'(trig_k - arm_edge)) begin
      n_fail++; $display("FAIL fall_trig_addr: got %0d want %0d", trig_addr, trig_k - arm_edge); end
    do_reads(DEPTH);
    fd = first_diff();
    n_checks++; if (fd >= 0 || got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL fall_window: read %0d got %h want %h (count %0d)", fd, got_at(fd), exp_q[fd % DEPTH], got_q.size()); end
    n_checks++; if (got_at(0) !== 8'hFC || got_at(3) !== 8'hFF || got_at(4) !== 8'h00) begin
      n_fail++; $display("FAIL fall_head: got %h %h %h want fc ff 00", got_at(0), got_at(3), got_at(4)); end
  endtask

  task automatic test_force_pre0();
    data_mode = 1;
    const_v   = 8'h3C;
    repeat (2) step();
    run_capture(0, 8'h00, 1'b1, 1'b1);
    build_expected(arm_edge, 0, 8'h00, 1'b1);
    n_checks++; if (done_edge !== arm_edge + DEPTH + 1) begin
      n_fail++; $display("FAIL force_done_time: edge %0d want %0d", done_edge, arm_edge + DEPTH + 1); end
    n_checks++; if (trig_k < 0 || trig_addr !== DEPTH_LOG2'(trig_k - arm_edge)) begin
      n_fail++; $display("FAIL force_trig_addr: got %0d want %0d", trig_addr, trig_k - arm_edge); end
    do_reads(DEPTH);
    fd = first_diff();
    n_checks++; if (fd >= 0 || got_q.size() != DEPTH || got_at(0) !== 8'h3C) begin
      n_fail++; $display("FAIL force_reads: read %0d got %h want 3c (count %0d)", fd, got_at(fd), got_q.size()); end
  endtask

  task automatic test_read_wrap_ignore();
    bit any_valid;
    data_mode = 0;
    run_capture(100, 8'h40, 1'b1, 1'b0);
    build_expected(arm_edge, 100, 8'h40, 1'b1);
    do_reads(DEPTH + 6);
    n_checks++; if (got_q.size() != DEPTH + 6) begin
      n_fail++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), DEPTH + 6); end
    fd = first_diff();
    n_checks++; if (fd >= 0) begin
      n_fail++; $display("FAIL wrap_window: read %0d got %h want %h", fd, got_at(fd), exp_q[fd % DEPTH]); end
    fd = -1;
    for (int i = 0; i < 6; i++) if (fd < 0 && got_at(DEPTH + i) !== got_at(i)) fd = i;
    n_checks++; if (fd >= 0) begin
      n_fail++; $display("FAIL wrap_repeat: read %0d got %h want %h", DEPTH + fd, got_at(DEPTH + fd), got_at(fd)); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    any_valid = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_valid !== 1'b0) any_valid = 1'b1;
    end
    rd_en = 1'b0;
    n_checks++; if (any_valid || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL idle_rd_ignored: valid seen %b data %h want 0 00", any_valid, rd_data); end
  endtask

  task automatic test_reset_rearm();
    data_mode   = 0;
    trig_level  = 8'h00;  // rising through 0 is impossible: only force triggers
    trig_rising = 1'b1;
    pre_trig    = 10'd8;
    arm = 1'b1; step(); arm = 1'b0;
    wait_wait_state();
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (50) step();
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL in_post: got %0d want 3", state); end
    rstn = 1'b0; step(); rstn = 1'b1;
    n_checks++; if (state !== 3'd0 || done !== 1'b0 || trig_addr !== '0) begin
      n_fail++; $display("FAIL post_reset: state %0d done %b taddr %0d want 0 0 0", state, done, trig_addr); end
    repeat (3) step();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL stay_idle: got %0d want 0", state); end
    arm = 1'b1; step(); arm = 1'b0;
    wait_wait_state();
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL reach_wait: got %0d want 2", state); end
    pre_trig = 10'd5;
    arm      = 1'b1;
    arm_edge = xs.size();
    step();
    arm = 1'b0;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL rearm_pre: got %0d want 1", state); end
    wait_wait_state();
    force_trig = 1'b1; step(); force_trig = 1'b0;
    wait_done(6000);
    build_expected(arm_edge, 5, 8'h00, 1'b1);
    n_checks++; if (trig_addr !== 10'd5 || trig_k - arm_edge != 5) begin
      n_fail++; $display("FAIL rearm_trig_addr: got %0d want 5 (model %0d)", trig_addr, trig_k - arm_edge); end
    n_checks++; if (done_edge !== trig_k + DEPTH - 5) begin
      n_fail++; $display("FAIL rearm_done_time: edge %0d want %0d", done_edge, trig_k + DEPTH - 5); end
    do_reads(DEPTH);
    fd = first_diff();
    n_checks++; if (fd >= 0 || got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL rearm_window: read %0d got %h want %h (count %0d)", fd, got_at(fd), exp_q[fd % DEPTH], got_q.size()); end
  endtask

  task automatic test_random();
    int         p;
    logic [7:0] lvl;
    bit         rising;
    data_mode = 2;
    for (int it = 0; it < 3; it++) begin
      p      = $urandom_range(1, 300);
      lvl    = 8'($urandom_range(8'h20, 8'hE0));
      rising = 1'($urandom_range(0, 1));
      run_capture(p, lvl, rising, 1'b0);
      build_expected(arm_edge, p, lvl, rising);
      n_checks++; if (trig_k < 0 || done_edge !== trig_k + DEPTH - p) begin
        n_fail++; $display("FAIL rand%0d_done_time: edge %0d want %0d", it, done_edge, trig_k + DEPTH - p); end
      n_checks++; if (trig_addr !== DEPTH_LOG2'(trig_k - arm_edge)) begin
        n_fail++; $display("FAIL rand%0d_trig_addr: got %0d want %0d", it, trig_addr, trig_k - arm_edge); end
      do_reads(DEPTH);
      fd = first_diff();
      n_checks++; if (fd >= 0 || got_q.size() != DEPTH) begin
        n_fail++; $display("FAIL rand%0d_window: read %0d got %h want %h (count %0d)", it, fd, got_at(fd), exp_q[fd % DEPTH], got_q.size()); end
    end
  endtask

  initial begin
    rstn        = 1'b0;
    arm         = 1'b0;
    force_trig  = 1'b0;
    rd_en       = 1'b0;
    trig_level  = 8'h00;
    trig_rising = 1'b1;
    pre_trig    = '0;
    adc_data    = '0;
    data_mode   = 1;
    const_v     = 8'h00;
    ramp_v      = 8'h00;

    test_reset();
    test_rising();
    test_falling();
    test_force_pre0();
    test_read_wrap_ignore();
    test_reset_rearm();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
